// File: rtl/neuron_spike_encoder.sv
// Spike detector, refractory filter, timestamper and event FIFO sitting behind the neuron model.
// Optional per-event inter-spike interval storage is enabled by defining NEURON_SPIKE_ISI_EN.
module neuron_spike_encoder #(
  parameter int TS_WIDTH       = 16,
  parameter int DEPTH          = 8,
  parameter int REFRACT_CYCLES = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     digital_sel_in,
  output logic                     spike_pulse,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_WIDTH-1:0]      ev_ts,
  output logic [TS_WIDTH-1:0]      ev_isi,
  output logic [CNT_WIDTH-1:0]     drop_cnt,
  output logic [CNT_WIDTH-1:0]     ovf_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(REFRACT_CYCLES + 2);
  localparam logic [RW-1:0] REF_LOAD = RW'(REFRACT_CYCLES);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic                 sel_q, sel_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [RW-1:0]        ref_cnt_q, ref_cnt_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
  logic                 pulse_q, pulse_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [TS_WIDTH-1:0]  mem_ts_q [DEPTH];
  logic [TS_WIDTH-1:0]  mem_ts_d [DEPTH];

  logic det, accept, drop, pop, push;

`ifdef NEURON_SPIKE_ISI_EN
  logic [TS_WIDTH-1:0]  last_ts_q, last_ts_d;
  logic                 have_last_q, have_last_d;
  logic [TS_WIDTH-1:0]  mem_isi_q [DEPTH];
  logic [TS_WIDTH-1:0]  mem_isi_d [DEPTH];
  logic [TS_WIDTH-1:0]  isi_new;
`endif

  // Valid comes only from the registered level, so ev_ready never reaches ev_valid.
  assign ev_valid    = (level_q != '0);
  assign spike_pulse = pulse_q;
  assign drop_cnt    = drop_q;
  assign ovf_cnt     = ovf_q;
  assign fifo_level  = level_q;
  assign ev_ts       = ev_valid ? mem_ts_q[rd_ptr_q] : '0;
`ifdef NEURON_SPIKE_ISI_EN
  assign ev_isi      = ev_valid ? mem_isi_q[rd_ptr_q] : '0;
`else
  assign ev_isi      = '0;
`endif

  always_comb begin
    det    = en & sel_q & ~digital_sel_in;
    accept = det & (ref_cnt_q == '0);
    drop   = det & (ref_cnt_q != '0);
    pop    = ev_valid & ev_ready;
    push   = accept & ((level_q != LVL_FULL) | pop);

    sel_d     = digital_sel_in;
    ts_d      = en ? ts_q + TS_WIDTH'(1) : ts_q;
    pulse_d   = accept;
    ref_cnt_d = ref_cnt_q;
    drop_d    = drop_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    mem_ts_d  = mem_ts_q;

    if (accept)
      ref_cnt_d = REF_LOAD;
    else if (en && ref_cnt_q != '0)
      ref_cnt_d = ref_cnt_q - RW'(1);

    if (drop && drop_q != '1)
      drop_d = drop_q + CNT_WIDTH'(1);
    if (accept && !push && ovf_q != '1)
      ovf_d = ovf_q + CNT_WIDTH'(1);

    if (push) begin
      mem_ts_d[wr_ptr_q] = ts_q;
      wr_ptr_d           = wr_ptr_q + AW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

`ifdef NEURON_SPIKE_ISI_EN
  // last_ts follows every accepted spike, even one that is then lost to a full FIFO.
  always_comb begin
    isi_new     = have_last_q ? ts_q - last_ts_q : '1;
    last_ts_d   = accept ? ts_q : last_ts_q;
    have_last_d = have_last_q | accept;
    mem_isi_d   = mem_isi_q;
    if (push)
      mem_isi_d[wr_ptr_q] = isi_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ts_q   <= '0;
      have_last_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_isi_q[i] <= '0;
    end else begin
      last_ts_q   <= last_ts_d;
      have_last_q <= have_last_d;
      mem_isi_q   <= mem_isi_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 1'b1;
      ts_q      <= '0;
      ref_cnt_q <= '0;
      drop_q    <= '0;
      ovf_q     <= '0;
      pulse_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_ts_q[i] <= '0;
    end else begin
      sel_q     <= sel_d;
      ts_q      <= ts_d;
      ref_cnt_q <= ref_cnt_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
      pulse_q   <= pulse_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      mem_ts_q  <= mem_ts_d;
    end
  end

endmodule

// File: tb/tb_neuron_spike_encoder.sv
// Bench for neuron_spike_encoder: directed scenarios plus random traffic against an event-level model.
// ISI expectations follow NEURON_SPIKE_ISI_EN the same way the design does.
module tb_neuron_spike_encoder;

  localparam int TSW     = 16;
  localparam int DEPTH   = 8;
  localparam int REFRACT = 4;
  localparam int CW      = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            digital_sel_in = 1'b1;
  logic            ev_ready = 1'b0;
  logic            spike_pulse, ev_valid;
  logic [TSW-1:0]  ev_ts, ev_isi;
  logic [CW-1:0]   drop_cnt, ovf_cnt;
  logic [3:0]      fifo_level;

  neuron_spike_encoder #(
    .TS_WIDTH(TSW), .DEPTH(DEPTH), .REFRACT_CYCLES(REFRACT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .digital_sel_in(digital_sel_in),
    .spike_pulse(spike_pulse), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_ts(ev_ts), .ev_isi(ev_isi), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int ts; int isi; } ev_t;
  ev_t q[$];
  int  m_ts, m_en_cnt, m_last_acc, m_last_ts, m_drop, m_ovf;
  bit  m_sel, m_has_last, m_pulse;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts = 0; m_en_cnt = 0; m_last_acc = 0; m_last_ts = 0;
    m_drop = 0; m_ovf = 0; m_sel = 1'b1; m_has_last = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic check_all();
    chk("pulse", 32'(spike_pulse), 32'(m_pulse));
    chk("valid", 32'(ev_valid), 32'(q.size() > 0));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    if (q.size() > 0) begin
      chk("ev_ts", 32'(ev_ts), 32'(q[0].ts));
`ifdef NEURON_SPIKE_ISI_EN
      chk("ev_isi", 32'(ev_isi), 32'(q[0].isi));
`endif
    end
`ifndef NEURON_SPIKE_ISI_EN
    chk("ev_isi_zero", 32'(ev_isi), 32'd0);
`endif
  endtask

  // One clock edge: drive inputs on the falling edge, advance the model at the rising edge.
  task automatic step(input logic s, input logic e, input logic r);
    bit   pop, det, acc;
    ev_t  ev;
    @(negedge clk);
    digital_sel_in = s; en = e; ev_ready = r;
    @(posedge clk);
    pop = (q.size() > 0) && r;
    det = e && m_sel && !s;
    acc = 1'b0;
    m_pulse = 1'b0;
    ev.ts = 0; ev.isi = 0;
    if (det) begin
      if (m_has_last && (m_en_cnt - m_last_acc) <= REFRACT) begin
        if (m_drop < 255) m_drop++;
      end else begin
        acc = 1'b1;
        m_pulse = 1'b1;
        ev.ts  = m_ts;
        ev.isi = m_has_last ? ((m_ts - m_last_ts) & 32'hFFFF) : 32'hFFFF;
        m_last_ts  = m_ts;
        m_last_acc = m_en_cnt;
        m_has_last = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (q.size() < DEPTH) q.push_back(ev);
      else if (m_ovf < 255) m_ovf++;
    end
    if (e) begin
      m_ts = (m_ts + 1) & 32'hFFFF;
      m_en_cnt++;
    end
    m_sel = s;
    #1 check_all();
  endtask

  // Reset lands between edges so its effect is checked before any clock arrives.
  task automatic do_reset();
    @(negedge clk);
    digital_sel_in = 1'b1; en = 1'b0; ev_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_pulse", 32'(spike_pulse), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_isi", 32'(ev_isi), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();

    // Single spike detected while ts = 10.
    do_reset();
    repeat (10) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("single_ts", 32'(ev_ts), 32'd10);
    chk("single_level", 32'(fifo_level), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("single_pulse_once", 32'(spike_pulse), 32'd0);

    // Spikes at ts 20, 23 and 25: the middle one falls in the refractory window.
    do_reset();
    repeat (20) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("refr_drop", 32'(drop_cnt), 32'd1);
    chk("refr_level", 32'(fifo_level), 32'd2);
    chk("refr_first_ts", 32'(ev_ts), 32'd20);
    step(1'b1, 1'b1, 1'b1);
    chk("refr_second_ts", 32'(ev_ts), 32'd25);
`ifdef NEURON_SPIKE_ISI_EN
    chk("refr_second_isi", 32'(ev_isi), 32'd5);
`endif

    // Ten accepted spikes into an undrained FIFO.
    do_reset();
    repeat (10) begin
      repeat (5) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_cnt", 32'(ovf_cnt), 32'd2);
    chk("ovf_head_ts", 32'(ev_ts), 32'd5);

    // Full FIFO, pop and push on the same edge.
    repeat (5) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("full_push_level", 32'(fifo_level), 32'd8);
    chk("full_push_ovf", 32'(ovf_cnt), 32'd2);

    // Build up three drops and drain to five entries, then reset mid-operation.
    repeat (5) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    chk("pre_rst_drop", 32'(drop_cnt), 32'd3);
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("ts_restart", 32'(ev_ts), 32'd3);

    // Edge while disabled is ignored; re-enabling with the input low creates nothing.
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("en0_level", 32'(fifo_level), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("en0_ts", 32'(ev_ts), 32'd5);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(logic'($urandom_range(0, 99) < 60),
           logic'($urandom_range(0, 99) < 90),
           logic'($urandom_range(0, 99) < 35));
      if (i == 900) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
